pwm_update_ctrl: RTL and testbench
==================================

Name: pwm_update_ctrl

Overview:
- Sequences duty updates from the SPI slave into the 10-channel PWM bank.
- Captures each received frame into a staging buffer and commits it to the live duty bus only at a PWM period boundary, so no channel ever produces a torn or glitched period.
- Owns the shared period counter that all pwm units compare against.
- Forces all duties to zero (failsafe) when the SPI host stops refreshing.

Parameters:
- NCH, 10, number of PWM channels.
- DW, 16, duty and counter width in bits; period = 2^DW clk cycles.
- WDOG_PERIODS, 50, consecutive periods with no frame before failsafe (50 × 65536 clk ≈ 65.5 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active high.
- rx_data_tick  in  1  single-cycle strobe, clk domain: rx_data valid.
- rx_data  in  NCH*DW  frame; ch i at bits [NCH*DW-1-i*DW -: DW] (ch0 in MSBs).
- pwm_cnt  out  DW  shared free-running period counter.
- period_start  out  1  high for the one cycle where pwm_cnt==0.
- duty  out  NCH*DW  live duty bus, same channel packing as rx_data.
- pending  out  1  a staged frame is awaiting commit.
- failsafe  out  1  watchdog expired; duty forced to zero.
- frame_drop  out  1  one-cycle pulse: a staged frame was overwritten before commit.

Behaviour:
- Reset: pwm_cnt=0, period_start=0, duty=0, pending=0, failsafe=0, frame_drop=0, state IDLE, watchdog count=0, staging buffer=0.
- pwm_cnt increments by 1 every clk and wraps 2^DW-1 → 0. period_start is registered and asserted exactly on cycles where pwm_cnt==0. The first such cycle is 2^DW clks after rst deasserts.
- Staging: on rx_data_tick, stage ← rx_data and pending ← 1 on the next edge. If pending was already 1, frame_drop pulses for one cycle and the newer frame wins.
- Commit: on a cycle with period_start=1 and pending=1, duty ← stage and pending ← 0 at that edge. Latency from tick to duty is 1..2^DW+1 clks.
- Tick and period_start in the same cycle: the tick's frame is not committed in that cycle. The previously staged frame, if any, commits; the new frame stays pending. No frame_drop in this case.
- States:
  - IDLE: no frame since reset/failsafe; duty=0. → ARMED on tick.
  - ARMED: pending=1. → RUN on commit.
  - RUN: duty live. Returns to ARMED on tick.
  - FAILSAFE: duty=0, failsafe=1. → ARMED on tick; failsafe clears on the commit edge.
- Watchdog: counter cleared by any rx_data_tick; incremented on each period_start without a tick. Saturates at WDOG_PERIODS.
- Failsafe entry: when the watchdog reaches WDOG_PERIODS in ARMED or RUN, on that edge duty ← 0, pending ← 0, failsafe ← 1, and the state moves to FAILSAFE. Tick on that same cycle wins: no failsafe, frame is staged.
- The watchdog is inactive in IDLE, so the startup duty is already 0.
- rst mid-operation returns everything to reset values on the next edge and discards the staged frame.

Optional Feature:
- Macro PWM_UPD_WDOG_EN.
- Defined: watchdog and FAILSAFE state as above.
- Undefined: no watchdog counter, FAILSAFE unreachable, failsafe tied 0; last committed duty is held indefinitely.

Decomposition:
- Shared package pwm_pkg holds:
  - NCH, DW constants.
  - channel slice helper (offset = NCH*DW-1-i*DW).
  - state enum {IDLE, ARMED, RUN, FAILSAFE}.
- One natural sub-module, pwm_period_timer: the pwm_cnt counter plus period_start generation. It is reused by the pwm units' bench.

Test Plan:
- Reset release, no ticks for 3 periods → duty=0, failsafe=0, period_start every 65536 clks beginning at clk 65536.
- Tick at pwm_cnt=100 with ch0=16'h8000, ch9=16'h0001 → pending=1 next clk; duty updates exactly at next pwm_cnt==0 edge; pending=0.
- Two ticks (A then B) within one period → frame_drop pulses once on B; B committed, A never appears on duty.
- Tick coincident with period_start while frame A pending → A commits this edge; new frame C commits at following boundary; no frame_drop.
- With PWM_UPD_WDOG_EN and WDOG_PERIODS=3: commit frame, then no ticks → failsafe=1 and duty=0 at 3rd period_start; next tick + boundary → duty restored, failsafe=0.
- rst asserted while pending=1 → next edge all outputs 0, staged frame never committed after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bank update path.
//   NCH, DW     : default channel count and duty/counter width
//   ch_msb()    : MSB index of channel i inside a packed frame (ch0 in MSBs)
//   upd_state_e : update-sequencer state encoding
package pwm_pkg;

  localparam int NCH = 10;
  localparam int DW  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2,
    FAILSAFE = 2'd3
  } upd_state_e;

  // Channel i occupies [ch_msb(i) -: dw] of an nch*dw frame.
  function automatic int ch_msb(input int i, input int nch, input int dw);
    return nch * dw - 1 - i * dw;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Shared PWM period counter.
//   i_clk          : system clock
//   i_rst          : synchronous reset, active high
//   o_pwm_cnt      : free-running counter, wraps 2^DW-1 -> 0
//   o_period_start : registered, high exactly on cycles where o_pwm_cnt == 0
//                    (not asserted in the cycle right after reset)
module pwm_period_timer #(
  parameter int DW = pwm_pkg::DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [DW-1:0] o_pwm_cnt,
  output logic          o_period_start
);

  logic [DW-1:0] r_cnt;
  logic          r_period_start;
  logic          w_wrap;

  // The counter is about to roll over to zero on this edge.
  assign w_wrap = (r_cnt == {DW{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= r_cnt + 1'b1;
      r_period_start <= w_wrap;
    end
  end

  assign o_pwm_cnt      = r_cnt;
  assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_update_ctrl.sv
// Duty update sequencer for the PWM bank.
// Stages each SPI frame and commits it to the live duty bus only on a
// period boundary, owns the shared period counter, and (optionally) forces
// all duties to zero when the SPI host stops refreshing.
//
// Optional feature macro: PWM_UPD_WDOG_EN
//   defined   : watchdog + FAILSAFE state active
//   undefined : no watchdog, o_failsafe tied 0, last duty held indefinitely
//
// Ports
//   i_clk          : system clock
//   i_rst          : synchronous reset, active high
//   i_rx_data_tick : one-cycle strobe, i_rx_data valid
//   i_rx_data      : frame, ch i at [NCH*DW-1-i*DW -: DW] (ch0 in MSBs)
//   o_pwm_cnt      : shared period counter
//   o_period_start : high on cycles where o_pwm_cnt == 0
//   o_duty         : live duty bus, same packing as i_rx_data
//   o_pending      : a staged frame awaits commit
//   o_failsafe     : watchdog expired, duty forced to zero
//   o_frame_drop   : one-cycle pulse, staged frame overwritten before commit
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no frame since reset; duty is zero
// ARMED    | a frame is staged and waits for the next period boundary
// RUN      | committed duty is live, nothing staged
// FAILSAFE | host went silent; duty zero, o_failsafe high until next commit
module pwm_update_ctrl #(
  parameter int NCH          = pwm_pkg::NCH,
  parameter int DW           = pwm_pkg::DW,
  parameter int WDOG_PERIODS = 50
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_data_tick,
  input  logic [NCH*DW-1:0] i_rx_data,
  output logic [DW-1:0]     o_pwm_cnt,
  output logic              o_period_start,
  output logic [NCH*DW-1:0] o_duty,
  output logic              o_pending,
  output logic              o_failsafe,
  output logic              o_frame_drop
);

  import pwm_pkg::*;

  if (WDOG_PERIODS < 1) begin : g_bad_wdog_periods
    $error("WDOG_PERIODS must be at least 1");
  end

  upd_state_e        r_state;
  upd_state_e        w_state_nxt;
  logic [NCH*DW-1:0] r_stage;
  logic [NCH*DW-1:0] r_duty;
  logic [NCH*DW-1:0] w_duty_nxt;
  logic              r_pending;
  logic              w_pending_nxt;
  logic              r_failsafe;
  logic              w_failsafe_nxt;
  logic              r_frame_drop;
  logic              w_frame_drop_nxt;
  logic              w_period_start;
  logic              w_commit;
  logic              w_wdog_hit;

  pwm_period_timer #(
    .DW(DW)
  ) u_period_timer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_pwm_cnt     (o_pwm_cnt),
    .o_period_start(w_period_start)
  );

  // A tick in a boundary cycle is staged, never committed in that cycle:
  // the commit always takes the frame staged before this edge.
  assign w_commit = w_period_start && r_pending;

`ifdef PWM_UPD_WDOG_EN
  localparam int WDW = $clog2(WDOG_PERIODS + 1);

  logic [WDW-1:0] r_wdog;
  logic           w_wdog_active;

  // Silent in IDLE (duty already zero) and in FAILSAFE (already tripped).
  assign w_wdog_active = (r_state == ARMED) || (r_state == RUN);

  // Trips on the edge where the count would reach WDOG_PERIODS; a tick in
  // the same cycle resets the count and wins.
  assign w_wdog_hit = w_wdog_active && w_period_start && !i_rx_data_tick &&
                      (r_wdog == WDW'(WDOG_PERIODS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wdog <= '0;
    end else if (i_rx_data_tick) begin
      r_wdog <= '0;
    end else if (w_wdog_active && w_period_start &&
                 (r_wdog != WDW'(WDOG_PERIODS))) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_wdog_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_stage      <= '0;
      r_duty       <= '0;
      r_pending    <= 1'b0;
      r_failsafe   <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_duty       <= w_duty_nxt;
      r_pending    <= w_pending_nxt;
      r_failsafe   <= w_failsafe_nxt;
      r_frame_drop <= w_frame_drop_nxt;
      if (i_rx_data_tick) begin
        r_stage <= i_rx_data;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_duty_nxt       = r_duty;
    w_pending_nxt    = r_pending;
    w_failsafe_nxt   = r_failsafe;
    w_frame_drop_nxt = 1'b0;

    if (i_rx_data_tick) begin
      w_pending_nxt    = 1'b1;
      // Overwrite only counts as a drop if the old frame isn't leaving
      // through a commit on this same edge.
      w_frame_drop_nxt = r_pending && !w_commit;
    end else if (w_commit) begin
      w_pending_nxt = 1'b0;
    end

    if (w_commit) begin
      w_duty_nxt     = r_stage;
      w_failsafe_nxt = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        if (i_rx_data_tick) begin
          w_state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (w_wdog_hit) begin
          w_state_nxt = FAILSAFE;
        end else if (i_rx_data_tick) begin
          w_state_nxt = ARMED;
        end else if (w_commit) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_wdog_hit) begin
          w_state_nxt = FAILSAFE;
        end else if (i_rx_data_tick) begin
          w_state_nxt = ARMED;
        end
      end
      FAILSAFE: begin
        if (i_rx_data_tick) begin
          w_state_nxt = ARMED;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Failsafe overrides any commit that would coincide with it.
    if (w_wdog_hit) begin
      w_duty_nxt     = '0;
      w_pending_nxt  = 1'b0;
      w_failsafe_nxt = 1'b1;
    end
  end

  assign o_period_start = w_period_start;
  assign o_duty         = r_duty;
  assign o_pending      = r_pending;
  assign o_failsafe     = r_failsafe;
  assign o_frame_drop   = r_frame_drop;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Directed bench for pwm_update_ctrl, built with DW=8 (256-clk periods)
// and WDOG_PERIODS=3 so every scenario fits in a few thousand cycles.
module tb_pwm_update_ctrl;

  localparam int NCH = 10;
  localparam int DW  = 8;
  localparam int W   = NCH * DW;
  localparam int WDP = 3;

`ifdef PWM_UPD_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam logic [W-1:0] FR_A = 80'h80_00_00_00_00_00_00_00_00_01;
  localparam logic [W-1:0] FR_P = 80'h11_22_33_44_55_66_77_88_99_00;
  localparam logic [W-1:0] FR_Q = 80'hA1_A2_A3_A4_A5_A6_A7_A8_A9_AA;
  localparam logic [W-1:0] FR_R = 80'h01_02_03_04_05_06_07_08_09_0A;
  localparam logic [W-1:0] FR_S = 80'hF0_E0_D0_C0_B0_A0_90_80_70_60;
  localparam logic [W-1:0] FR_T = 80'h55_55_55_55_55_55_55_55_55_55;
  localparam logic [W-1:0] FR_U = 80'hFF_FF_FF_FF_FF_FF_FF_FF_FF_FF;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [W-1:0]  rx_data;
  logic [DW-1:0] pwm_cnt;
  logic          period_start;
  logic [W-1:0]  duty;
  logic          pending;
  logic          failsafe;
  logic          frame_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_update_ctrl #(
    .NCH         (NCH),
    .DW          (DW),
    .WDOG_PERIODS(WDP)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_data_tick(tick),
    .i_rx_data     (rx_data),
    .o_pwm_cnt     (pwm_cnt),
    .o_period_start(period_start),
    .o_duty        (duty),
    .o_pending     (pending),
    .o_failsafe    (failsafe),
    .o_frame_drop  (frame_drop)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] f);
    tick    = 1'b1;
    rx_data = f;
    step(1);
    tick    = 1'b0;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    tick    = 1'b0;
    rx_data = '0;
    step(3);
    chk_cnt("rst_cnt", pwm_cnt, 8'd0);
    chk_bit("rst_ps", period_start, 1'b0);
    chk_bus("rst_duty", duty, '0);
    chk_bit("rst_pending", pending, 1'b0);
    chk_bit("rst_failsafe", failsafe, 1'b0);
    chk_bit("rst_drop", frame_drop, 1'b0);

    // Release reset; first boundary 256 clks later, then no ticks.
    rst = 1'b0;
    step(1);
    chk_cnt("cnt_t1", pwm_cnt, 8'd1);
    step(254);
    chk_cnt("cnt_t255", pwm_cnt, 8'd255);
    chk_bit("ps_t255", period_start, 1'b0);
    step(1);
    chk_cnt("cnt_t256", pwm_cnt, 8'd0);
    chk_bit("ps_t256", period_start, 1'b1);
    step(1);
    chk_bit("ps_t257", period_start, 1'b0);
    step(255);
    chk_bit("ps_t512", period_start, 1'b1);
    step(256);
    chk_bit("ps_t768", period_start, 1'b1);
    chk_bus("idle_duty", duty, '0);
    chk_bit("idle_failsafe", failsafe, 1'b0);
    chk_bit("idle_pending", pending, 1'b0);

    // Single frame at pwm_cnt=100, commit at the next boundary cycle's edge.
    step(100);
    chk_cnt("cnt_100", pwm_cnt, 8'd100);
    send(FR_A);
    chk_bit("a_pending", pending, 1'b1);
    chk_bus("a_duty_pre", duty, '0);
    step(154);
    chk_cnt("a_cnt255", pwm_cnt, 8'd255);
    chk_bus("a_duty_255", duty, '0);
    step(1);
    chk_bit("a_ps", period_start, 1'b1);
    chk_bit("a_pending_ps", pending, 1'b1);
    step(1);
    chk_bus("a_duty", duty, FR_A);
    chk_cnt("a_ch0", duty[79:72], 8'h80);
    chk_cnt("a_ch9", duty[7:0], 8'h01);
    chk_bit("a_pending_clr", pending, 1'b0);

    // Two frames in one period: second wins, one drop pulse.
    step(9);
    send(FR_P);
    chk_bit("p_drop", frame_drop, 1'b0);
    chk_bit("p_pending", pending, 1'b1);
    step(9);
    chk_cnt("q_cnt20", pwm_cnt, 8'd20);
    send(FR_Q);
    chk_bit("q_drop", frame_drop, 1'b1);
    step(1);
    chk_bit("q_drop_end", frame_drop, 1'b0);
    step(233);
    chk_bus("q_duty_old", duty, FR_A);
    step(1);
    chk_bit("q_ps", period_start, 1'b1);
    step(1);
    chk_bus("q_duty", duty, FR_Q);
    chk_bit("q_pending_clr", pending, 1'b0);

    // Tick in the boundary cycle while R pending: R commits, S stays staged.
    step(9);
    send(FR_R);
    step(244);
    chk_cnt("r_cnt255", pwm_cnt, 8'd255);
    step(1);
    chk_bit("r_ps", period_start, 1'b1);
    send(FR_S);
    chk_bus("r_duty", duty, FR_R);
    chk_bit("s_pending", pending, 1'b1);
    chk_bit("s_no_drop", frame_drop, 1'b0);
    step(254);
    chk_bus("s_duty_hold", duty, FR_R);
    step(2);
    chk_bus("s_duty", duty, FR_S);
    chk_bit("s_pending_clr", pending, 1'b0);

    // Silence after S: the S commit boundary is watchdog period 1, trip at 3.
    step(255);
    step(1);
    chk_bus("wd_p2_duty", duty, FR_S);
    chk_bit("wd_p2_fs", failsafe, 1'b0);
    step(256);
    chk_bit("wd_p3_fs", failsafe, WD);
    chk_bus("wd_p3_duty", duty, WD ? '0 : FR_S);
    chk_bit("wd_p3_pending", pending, 1'b0);
    step(9);
    send(FR_T);
    chk_bit("t_pending", pending, 1'b1);
    chk_bit("t_fs_hold", failsafe, WD);
    step(246);
    chk_bus("t_duty", duty, FR_T);
    chk_bit("t_fs_clr", failsafe, 1'b0);

    // Reset while a frame is pending discards it.
    step(9);
    send(FR_U);
    chk_bit("u_pending", pending, 1'b1);
    rst = 1'b1;
    step(1);
    chk_cnt("mrst_cnt", pwm_cnt, 8'd0);
    chk_bus("mrst_duty", duty, '0);
    chk_bit("mrst_pending", pending, 1'b0);
    chk_bit("mrst_ps", period_start, 1'b0);
    chk_bit("mrst_drop", frame_drop, 1'b0);
    chk_bit("mrst_fs", failsafe, 1'b0);
    rst = 1'b0;
    step(256);
    chk_bit("post_ps", period_start, 1'b1);
    chk_bit("post_pending", pending, 1'b0);
    step(1);
    chk_bus("post_duty", duty, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
